fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Owns the program counter and the IF/ID pipeline register of the 5-stage pipelined core.
- Consumes the hazard unit's PC enable, IF/ID stall, bubble and flush controls, plus branch and jump redirects.
- Drives the instruction-memory request.
- Feeds the decode stage, and feeds the current fetched word back to the hazard unit for branch-flush detection.

Parameters:
- PC_INIT, 32'h00000000, PC value loaded on reset.
- HALT_OP, 6'b111111, opcode field (bits 31:26) identifying HALT.

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- ihit  input  1  instruction memory returned imemload this cycle.
- imemload  input  32  instruction word at imemaddr.
- pc_en  input  1  PC may advance (hazard unit PC-enable output).
- if_id_stall  input  1  hold IF/ID contents.
- if_id_bubble  input  1  insert NOP into IF/ID.
- if_id_flush  input  1  squash IF/ID contents.
- branch_taken  input  1  resolved branch redirect.
- branch_target  input  32  branch destination.
- jump_en  input  1  J/JAL/JR redirect.
- jump_target  input  32  jump destination.
- halt  input  1  HALT has retired downstream.
- imemREN  output  1  instruction read enable.
- imemaddr  output  32  current PC.
- if_id_instr  output  32  decoded-stage instruction.
- if_id_npc  output  32  PC+4 of if_id_instr.
- if_id_valid  output  1  IF/ID holds a real instruction.
- fetch_halted  output  1  fetch has stopped on HALT.

Behaviour:
- Reset (nRST low, async): PC=PC_INIT, if_id_instr=0, if_id_npc=0, if_id_valid=0, redir_pend=0, redir_addr=0, state=RUN.
- Reset-derived outputs: imemREN=1, fetch_halted=0.
- Reset mid-operation discards any pending redirect or halt state.
- imemaddr is the PC register.
- Redirect target: branch_target if branch_taken, else jump_target. Branch wins when both are asserted, because the branch is older.
- Bits [1:0] of any target are forced to 0.
- PC next-state, in priority order:
  1. Redirect request (branch_taken|jump_en) while if_id_stall=0: PC=target, redir_pend cleared.
  2. Redirect request while if_id_stall=1: target captured into redir_addr, redir_pend=1, PC held.
  3. redir_pend=1 and if_id_stall=0: PC=redir_addr, redir_pend cleared.
  4. pc_en=1 and state=RUN: PC=PC+4, modulo 2^32, so 32'hFFFFFFFC wraps to 0.
  5. Otherwise PC held.
- A new redirect arriving while redir_pend=1 overwrites redir_addr (youngest resolution wins).
- IF/ID register, in priority order:
  - if_id_flush: instr=0, npc=0, valid=0.
  - if_id_stall: hold all fields.
  - if_id_bubble or state!=RUN: instr=0, valid=0, npc held.
  - Otherwise: instr=imemload, npc=PC+4, valid=1.
- Latency: an instruction at PC appears on if_id_instr one cycle after the cycle with ihit=1 and no stall, flush or bubble.
- Halt FSM:
  - RUN → STOPPING when an instruction with imemload[31:26]==HALT_OP is loaded into IF/ID (load case above). The PC does not advance past HALT.
  - STOPPING → RUN on if_id_flush or a taken redirect (HALT was on the wrong path); the redirect is applied to the PC as above.
  - STOPPING → HALTED on halt=1. halt=1 in RUN also goes to HALTED.
  - HALTED is absorbing until reset.
- Outputs by state:
  - imemREN = (state==RUN).
  - fetch_halted = (state!=RUN).
- Simultaneous flush and HALT load in the same cycle: flush wins and state stays RUN.

Test Plan:
- Reset with PC_INIT=0; ihit=1, pc_en=1, imemload=32'h20010005 for 3 cycles → imemaddr 0,4,8; if_id_instr=32'h20010005, if_id_npc=4 then 8, if_id_valid=1.
- ihit=0 for 2 cycles (bubble=1, pc_en=0) → PC held at 8; if_id_valid=0, if_id_instr=0; fetch resumes once ihit returns.
- if_id_stall=1 with branch_taken=1, branch_target=32'h00000042 → PC held while stall=1; on stall release, PC=32'h40 (low bits cleared). Add jump_en same cycle with jump_target=0x100 → branch target still used.
- Flush: if_id_flush=1 with ihit=1 → IF/ID instr=0, npc=0, valid=0 next cycle.
- PC=32'hFFFFFFFC with pc_en=1 → PC becomes 0.
- Fetch imemload=32'hFC000000 → fetch_halted=1, imemREN=0, PC frozen. Then:
  - if_id_flush → back to RUN, imemREN=1.
  - Repeat the HALT fetch then assert halt=1 → fetch_halted stays 1 through later flushes until nRST pulse.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: program counter, IF/ID pipeline register and fetch halt control
// for the 5-stage pipelined core. A redirect that resolves while IF/ID is
// stalled is parked in a one-entry pending slot. The pending target is applied
// to the PC as soon as the stall releases.
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000,
  parameter logic [5:0]  HALT_OP = 6'b111111
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        pc_en,
  input  logic        if_id_stall,
  input  logic        if_id_bubble,
  input  logic        if_id_flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump_en,
  input  logic [31:0] jump_target,
  input  logic        halt,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_npc,
  output logic        if_id_valid,
  output logic        fetch_halted
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_STOPPING = 2'b01,
    ST_HALTED   = 2'b10
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [31:0] r_pc;
  logic [31:0] w_pc_next;
  logic        r_redir_pend;
  logic        w_redir_pend_next;
  logic [31:0] r_redir_addr;
  logic [31:0] w_redir_addr_next;

  logic [31:0] r_if_id_instr;
  logic [31:0] w_if_id_instr_next;
  logic [31:0] r_if_id_npc;
  logic [31:0] w_if_id_npc_next;
  logic        r_if_id_valid;
  logic        w_if_id_valid_next;

  logic        r_imem_ren;
  logic        r_fetch_halted;

  logic [31:0] w_pc_plus4;
  logic        w_redir_req;
  logic [31:0] w_redir_target;
  logic        w_load;
  logic        w_halt_load;

  // PC+4 wraps naturally at 2^32.
  assign w_pc_plus4 = r_pc + 32'd4;

  // Branch is older than a jump in the same cycle, so it wins; word-align.
  assign w_redir_req    = branch_taken | jump_en;
  assign w_redir_target = (branch_taken ? branch_target : jump_target) & 32'hFFFF_FFFC;

  // A real instruction enters IF/ID only when memory answered and nothing
  // squashes, holds or bubbles the register. A missing ihit is treated like
  // a bubble so a stale bus word can never be marked valid.
  assign w_load      = (~if_id_flush) & (~if_id_stall) & (~if_id_bubble) & ihit &
                       (r_state == ST_RUN);
  assign w_halt_load = w_load & (imemload[31:26] == HALT_OP);

  // Next PC and pending-redirect slot, highest priority first.
  always_comb begin
    w_pc_next         = r_pc;
    w_redir_pend_next = r_redir_pend;
    w_redir_addr_next = r_redir_addr;
    if (w_redir_req && !if_id_stall) begin
      w_pc_next         = w_redir_target;
      w_redir_pend_next = 1'b0;
    end else if (w_redir_req && if_id_stall) begin
      // Youngest resolution overwrites any earlier parked target.
      w_redir_addr_next = w_redir_target;
      w_redir_pend_next = 1'b1;
    end else if (r_redir_pend && !if_id_stall) begin
      w_pc_next         = r_redir_addr;
      w_redir_pend_next = 1'b0;
    end else if (pc_en && (r_state == ST_RUN) && !w_halt_load) begin
      // HALT freezes the PC on its own address.
      w_pc_next = w_pc_plus4;
    end else begin
      w_pc_next = r_pc;
    end
  end

  // Next IF/ID contents: flush beats stall beats bubble/halt beats load.
  always_comb begin
    w_if_id_instr_next = r_if_id_instr;
    w_if_id_npc_next   = r_if_id_npc;
    w_if_id_valid_next = r_if_id_valid;
    if (if_id_flush) begin
      w_if_id_instr_next = 32'h0000_0000;
      w_if_id_npc_next   = 32'h0000_0000;
      w_if_id_valid_next = 1'b0;
    end else if (if_id_stall) begin
      w_if_id_instr_next = r_if_id_instr;
      w_if_id_npc_next   = r_if_id_npc;
      w_if_id_valid_next = r_if_id_valid;
    end else if (!w_load) begin
      // Bubble, no ihit, or fetch stopped: insert a NOP, keep npc.
      w_if_id_instr_next = 32'h0000_0000;
      w_if_id_npc_next   = r_if_id_npc;
      w_if_id_valid_next = 1'b0;
    end else begin
      w_if_id_instr_next = imemload;
      w_if_id_npc_next   = w_pc_plus4;
      w_if_id_valid_next = 1'b1;
    end
  end

  // Halt FSM next state. A retired HALT is authoritative, so halt is checked
  // before the wrong-path exits out of STOPPING.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN: begin
        if (halt) begin
          w_state_next = ST_HALTED;
        end else if (w_halt_load) begin
          w_state_next = ST_STOPPING;
        end else begin
          w_state_next = ST_RUN;
        end
      end
      ST_STOPPING: begin
        if (halt) begin
          w_state_next = ST_HALTED;
        end else if (if_id_flush || w_redir_req) begin
          w_state_next = ST_RUN;
        end else begin
          w_state_next = ST_STOPPING;
        end
      end
      ST_HALTED: begin
        w_state_next = ST_HALTED;
      end
      default: begin
        // Unreachable encoding: fail safe by stopping fetch.
        w_state_next = ST_HALTED;
      end
    endcase
  end

  // PC and pending-redirect registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_pc         <= PC_INIT;
      r_redir_pend <= 1'b0;
      r_redir_addr <= 32'h0000_0000;
    end else begin
      r_pc         <= w_pc_next;
      r_redir_pend <= w_redir_pend_next;
      r_redir_addr <= w_redir_addr_next;
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_if_id_instr <= 32'h0000_0000;
      r_if_id_npc   <= 32'h0000_0000;
      r_if_id_valid <= 1'b0;
    end else begin
      r_if_id_instr <= w_if_id_instr_next;
      r_if_id_npc   <= w_if_id_npc_next;
      r_if_id_valid <= w_if_id_valid_next;
    end
  end

  // Halt FSM state plus its registered status outputs.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state        <= ST_RUN;
      r_imem_ren     <= 1'b1;
      r_fetch_halted <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_imem_ren     <= (w_state_next == ST_RUN);
      r_fetch_halted <= (w_state_next != ST_RUN);
    end
  end

  assign imemREN      = r_imem_ren;
  assign imemaddr     = r_pc;
  assign if_id_instr  = r_if_id_instr;
  assign if_id_npc    = r_if_id_npc;
  assign if_id_valid  = r_if_id_valid;
  assign fetch_halted = r_fetch_halted;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage with a few hand-written
// multi-cycle sequences (async reset mid-run, flush vs HALT, halt in RUN).
module tb_fetch_stage;

  logic        CLK;
  logic        nRST;
  logic        ihit;
  logic [31:0] imemload;
  logic        pc_en;
  logic        if_id_stall;
  logic        if_id_bubble;
  logic        if_id_flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump_en;
  logic [31:0] jump_target;
  logic        halt;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_npc;
  logic        if_id_valid;
  logic        fetch_halted;

  int checks;
  int failures;

  typedef struct {
    logic        ihit;
    logic [31:0] load;
    logic        pc_en;
    logic        stall;
    logic        bubble;
    logic        flush;
    logic        br;
    logic [31:0] br_tgt;
    logic        j;
    logic [31:0] j_tgt;
    logic        halt;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_npc;
    logic        e_valid;
    logic        e_ren;
    logic        e_halted;
  } vec_t;

  vec_t vecs [20];

  fetch_stage #(
    .PC_INIT(32'h0000_0000),
    .HALT_OP(6'b111111)
  ) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .ihit         (ihit),
    .imemload     (imemload),
    .pc_en        (pc_en),
    .if_id_stall  (if_id_stall),
    .if_id_bubble (if_id_bubble),
    .if_id_flush  (if_id_flush),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump_en      (jump_en),
    .jump_target  (jump_target),
    .halt         (halt),
    .imemREN      (imemREN),
    .imemaddr     (imemaddr),
    .if_id_instr  (if_id_instr),
    .if_id_npc    (if_id_npc),
    .if_id_valid  (if_id_valid),
    .fetch_halted (fetch_halted)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ihit          = 1'b0;
    imemload      = 32'h0000_0000;
    pc_en         = 1'b0;
    if_id_stall   = 1'b0;
    if_id_bubble  = 1'b1;
    if_id_flush   = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0000_0000;
    jump_en       = 1'b0;
    jump_target   = 32'h0000_0000;
    halt          = 1'b0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    //          ihit  load           pc_en stall bubble flush br    br_tgt         j     j_tgt          halt  e_pc           e_instr        e_npc          e_valid e_ren e_halted
    vecs[0]  = '{1'b1, 32'h20010005, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 32'h00000004, 32'h20010005, 32'h00000004, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 32'h20010005, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 32'h00000008, 32'h20010005, 32'h00000008, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 32'h00000008, 32'h00000000, 32'h00000008, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 32'h00000008, 32'h00000000, 32'h00000008, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 32'h8C220000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 32'h0000000C, 32'h8C220000, 32'h0000000C, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 32'hAAAAAAAA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h00000042, 1'b1, 32'h00000100, 1'b0, 32'h0000000C, 32'h8C220000, 32'h0000000C, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 32'hAAAAAAAA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 32'h0000000C, 32'h8C220000, 32'h0000000C, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 32'h11111111, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 32'h00000040, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 32'h20030007, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 32'h00000044, 32'h20030007, 32'h00000044, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 32'hAC010000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 32'h00000103, 1'b0, 32'h00000100, 32'hAC010000, 32'h00000048, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 32'h12345678, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 32'h00000104, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 32'h00430820, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 32'h00000000, 1'b0, 32'hFFFFFFFC, 32'h00430820, 32'h00000108, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 32'h00000001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 32'hFC000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 32'hFC000000, 32'h00000004, 1'b1, 1'b0, 1'b1};
    vecs[14] = '{1'b1, 32'h20010005, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 32'h00000000, 32'h00000004, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{1'b1, 32'h20010005, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 1'b0};
    vecs[16] = '{1'b1, 32'hFC000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 32'hFC000000, 32'h00000004, 1'b1, 1'b0, 1'b1};
    vecs[17] = '{1'b1, 32'h20010005, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b1, 32'h00000000, 32'h00000000, 32'h00000004, 1'b0, 1'b0, 1'b1};
    vecs[18] = '{1'b1, 32'h20010005, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1};
    vecs[19] = '{1'b1, 32'h20010005, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00000200, 1'b0, 32'h00000000, 1'b0, 32'h00000200, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1};

    // Reset state
    idle_inputs();
    nRST = 1'b0;
    #12;
    check("rst_pc",     imemaddr,              32'h0000_0000);
    check("rst_instr",  if_id_instr,           32'h0000_0000);
    check("rst_npc",    if_id_npc,             32'h0000_0000);
    check("rst_valid",  {31'd0, if_id_valid},  32'd0);
    check("rst_ren",    {31'd0, imemREN},      32'd1);
    check("rst_halted", {31'd0, fetch_halted}, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;

    // Table-driven main sequence
    for (int i = 0; i < 20; i++) begin
      ihit          = vecs[i].ihit;
      imemload      = vecs[i].load;
      pc_en         = vecs[i].pc_en;
      if_id_stall   = vecs[i].stall;
      if_id_bubble  = vecs[i].bubble;
      if_id_flush   = vecs[i].flush;
      branch_taken  = vecs[i].br;
      branch_target = vecs[i].br_tgt;
      jump_en       = vecs[i].j;
      jump_target   = vecs[i].j_tgt;
      halt          = vecs[i].halt;
      tick();
      check($sformatf("v%0d_pc", i),     imemaddr,              vecs[i].e_pc);
      check($sformatf("v%0d_instr", i),  if_id_instr,           vecs[i].e_instr);
      check($sformatf("v%0d_npc", i),    if_id_npc,             vecs[i].e_npc);
      check($sformatf("v%0d_valid", i),  {31'd0, if_id_valid},  {31'd0, vecs[i].e_valid});
      check($sformatf("v%0d_ren", i),    {31'd0, imemREN},      {31'd0, vecs[i].e_ren});
      check($sformatf("v%0d_halted", i), {31'd0, fetch_halted}, {31'd0, vecs[i].e_halted});
    end

    // Seq A: park a redirect while HALTED, then async reset mid-cycle
    idle_inputs();
    if_id_bubble  = 1'b0;
    if_id_stall   = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0300;
    tick();
    check("seqA_pc_held", imemaddr, 32'h0000_0200);
    #2;
    nRST = 1'b0;
    #1;
    check("seqA_async_pc",     imemaddr,              32'h0000_0000);
    check("seqA_async_ren",    {31'd0, imemREN},      32'd1);
    check("seqA_async_halted", {31'd0, fetch_halted}, 32'd0);
    check("seqA_async_npc",    if_id_npc,             32'h0000_0000);
    idle_inputs();
    @(negedge CLK);
    nRST = 1'b1;
    tick();
    check("seqA_pend_discarded", imemaddr,              32'h0000_0000);
    check("seqA_run_after_rst",  {31'd0, fetch_halted}, 32'd0);

    // Seq B: flush and HALT load in the same cycle, flush wins
    idle_inputs();
    if_id_bubble = 1'b0;
    ihit         = 1'b1;
    pc_en        = 1'b1;
    imemload     = 32'hFC00_0000;
    if_id_flush  = 1'b1;
    tick();
    check("seqB_pc",     imemaddr,              32'h0000_0004);
    check("seqB_valid",  {31'd0, if_id_valid},  32'd0);
    check("seqB_halted", {31'd0, fetch_halted}, 32'd0);
    check("seqB_ren",    {31'd0, imemREN},      32'd1);

    // Seq C: HALT load, then a jump while STOPPING returns to RUN
    if_id_flush = 1'b0;
    tick();
    check("seqC_pc_frozen", imemaddr,              32'h0000_0004);
    check("seqC_instr",     if_id_instr,           32'hFC00_0000);
    check("seqC_npc",       if_id_npc,             32'h0000_0008);
    check("seqC_halted",    {31'd0, fetch_halted}, 32'd1);
    jump_en     = 1'b1;
    jump_target = 32'h0000_0081;
    imemload    = 32'h2001_0005;
    tick();
    check("seqC_jump_pc",  imemaddr,              32'h0000_0080);
    check("seqC_ren_back", {31'd0, imemREN},      32'd1);
    check("seqC_valid",    {31'd0, if_id_valid},  32'd0);
    check("seqC_npc_held", if_id_npc,             32'h0000_0008);

    // Seq D: halt while in RUN goes straight to HALTED and sticks
    idle_inputs();
    halt = 1'b1;
    tick();
    check("seqD_halted", {31'd0, fetch_halted}, 32'd1);
    check("seqD_ren",    {31'd0, imemREN},      32'd0);
    check("seqD_pc",     imemaddr,              32'h0000_0080);
    halt        = 1'b0;
    if_id_flush = 1'b1;
    tick();
    check("seqD_sticky", {31'd0, fetch_halted}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
